// File: rtl/hazard_control.sv
// Pipeline sequencing controller: load-use stalls, branch squash, halt/drain, event counters.
// Latency: control outputs are combinational (Mealy) from state and inputs; state/counters update on the next edge.
// Backpressure: freezes PC and IF/ID during stall/drain/halt; branch flush overrides stall and drain.
module hazard_control #(
    parameter int STALL_CYCLES = 1,
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       IF_ID_rs,
    input  logic [4:0]       IF_ID_rt,
    input  logic             IF_ID_uses_rt,
    input  logic             ID_EX_memread,
    input  logic [4:0]       ID_EX_rt,
    input  logic             EX_MEM_PCSrc,
    input  logic             halt_req,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_bubble,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {RUN, STALL, DRAIN, HALT} state_t;

    // The first stalled cycle is spent in RUN, so STALL only covers the remainder.
    localparam int          STALL_RELOAD_I = (STALL_CYCLES > 1) ? (STALL_CYCLES - 2) : 0;
    localparam int          DRAIN_RELOAD_I = DRAIN_CYCLES - 1;
    localparam logic [3:0]  STALL_RELOAD   = STALL_RELOAD_I[3:0];
    localparam logic [3:0]  DRAIN_RELOAD   = DRAIN_RELOAD_I[3:0];

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;
    logic             haz;
    logic             stall_inc;
    logic             flush_inc;

    // Load-use hazard: a load in ID/EX writes a register the IF/ID instruction reads ($0 excluded).
    always_comb begin
        haz = ID_EX_memread && (ID_EX_rt != 5'd0) &&
              ((ID_EX_rt == IF_ID_rs) || (IF_ID_uses_rt && (ID_EX_rt == IF_ID_rt)));
    end

    // Next-state and Mealy outputs; priority is reset, branch flush, halt request, hazard.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        halted       = 1'b0;
        if (!rst_n) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            state_d      = RUN;
            cnt_d        = 4'd0;
        end else if (state_q == HALT) begin
            // Pipeline is empty: a stale branch resolution has nothing to squash.
            halted       = 1'b1;
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            if (!halt_req) begin
                state_d = RUN;
            end
        end else if (EX_MEM_PCSrc) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            flush_inc    = 1'b1;
            if ((state_q == DRAIN) && halt_req) begin
                // Branch target was just fetched; restart the drain window behind it.
                state_d = DRAIN;
                cnt_d   = DRAIN_RELOAD;
            end else begin
                state_d = RUN;
                cnt_d   = 4'd0;
            end
        end else begin
            case (state_q)
                DRAIN: begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                    if (!halt_req) begin
                        state_d = RUN;
                        cnt_d   = 4'd0;
                    end else if (cnt_q == 4'd0) begin
                        state_d = HALT;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                RUN, STALL: begin
                    if (halt_req) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_bubble = 1'b1;
                        state_d      = DRAIN;
                        cnt_d        = DRAIN_RELOAD;
                    end else if (state_q == STALL) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_bubble = 1'b1;
                        stall_inc    = 1'b1;
                        if (cnt_q == 4'd0) begin
                            state_d = RUN;
                        end else begin
                            cnt_d = cnt_q - 4'd1;
                        end
                    end else if (haz) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_bubble = 1'b1;
                        stall_inc    = 1'b1;
                        if (STALL_CYCLES > 1) begin
                            state_d = STALL;
                            cnt_d   = STALL_RELOAD;
                        end
                    end
                end
                default: begin
                    state_d = RUN;
                    cnt_d   = 4'd0;
                end
            endcase
        end
    end

    // Saturating event counters: hold at all-ones instead of wrapping.
    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (stall_inc && (stall_count_q != {CNT_W{1'b1}})) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
        if (flush_inc && (flush_count_q != {CNT_W{1'b1}})) begin
            flush_count_d = flush_count_q + CNT_W'(1);
        end
    end

    // State, down-counter and event counters with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= RUN;
            cnt_q         <= 4'd0;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;

endmodule

// File: tb/tb_hazard_control.sv
// Bench for hazard_control: two instances (default params; STALL_CYCLES=3 with CNT_W=2).
// Inputs change 1ns after the rising edge; outputs are checked against a model on the falling edge.
// Directed literal checks pin the model at the key points of each scenario.
module tb_hazard_control;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [4:0] if_id_rs, if_id_rt, id_ex_rt;
    logic       uses_rt, memread, pcsrc, halt_req;

    logic        a_pc, a_ifw, a_bub, a_iff, a_idf, a_exf, a_hlt;
    logic [15:0] a_sc, a_fc;
    logic        b_pc, b_ifw, b_bub, b_iff, b_idf, b_exf, b_hlt;
    logic [1:0]  b_sc, b_fc;

    hazard_control dut_a (
        .clk(clk), .rst_n(rst_n), .IF_ID_rs(if_id_rs), .IF_ID_rt(if_id_rt),
        .IF_ID_uses_rt(uses_rt), .ID_EX_memread(memread), .ID_EX_rt(id_ex_rt),
        .EX_MEM_PCSrc(pcsrc), .halt_req(halt_req), .pc_write(a_pc), .if_id_write(a_ifw),
        .id_ex_bubble(a_bub), .if_id_flush(a_iff), .id_ex_flush(a_idf), .ex_mem_flush(a_exf),
        .halted(a_hlt), .stall_count(a_sc), .flush_count(a_fc)
    );

    hazard_control #(.STALL_CYCLES(3), .DRAIN_CYCLES(4), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .IF_ID_rs(if_id_rs), .IF_ID_rt(if_id_rt),
        .IF_ID_uses_rt(uses_rt), .ID_EX_memread(memread), .ID_EX_rt(id_ex_rt),
        .EX_MEM_PCSrc(pcsrc), .halt_req(halt_req), .pc_write(b_pc), .if_id_write(b_ifw),
        .id_ex_bubble(b_bub), .if_id_flush(b_iff), .id_ex_flush(b_idf), .ex_mem_flush(b_exf),
        .halted(b_hlt), .stall_count(b_sc), .flush_count(b_fc)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model state: remaining frozen cycles, drain progress, halted flag, event totals.
    typedef struct {
        int stall_left;
        int drain_left;
        bit draining;
        bit halted;
        int scnt;
        int fcnt;
    } mst_t;

    typedef struct {
        bit pc;
        bit ifw;
        bit bub;
        bit fl;
        bit hlt;
    } mout_t;

    function automatic int sat_inc(input int v, input int cmax);
        return (v >= cmax) ? cmax : v + 1;
    endfunction

    function automatic void model(input mst_t s, input int sc, input int dr, input int cmax,
                                  output mst_t n, output mout_t o);
        bit haz;
        haz = memread && (id_ex_rt != 0) &&
              ((id_ex_rt == if_id_rs) || (uses_rt && (id_ex_rt == if_id_rt)));
        n = s;
        o = '{pc: 1, ifw: 1, bub: 0, fl: 0, hlt: 0};
        if (!rst_n) begin
            o = '{pc: 0, ifw: 0, bub: 1, fl: 1, hlt: 0};
            n = '{stall_left: 0, drain_left: 0, draining: 0, halted: 0, scnt: 0, fcnt: 0};
        end else if (s.halted) begin
            o = '{pc: 0, ifw: 0, bub: 1, fl: 0, hlt: 1};
            if (!halt_req) n.halted = 0;
        end else if (pcsrc) begin
            o.fl         = 1;
            n.fcnt       = sat_inc(s.fcnt, cmax);
            n.stall_left = 0;
            n.draining   = s.draining && halt_req;
            n.drain_left = dr - 1;
        end else if (s.draining) begin
            o = '{pc: 0, ifw: 0, bub: 1, fl: 0, hlt: 0};
            if (!halt_req) begin
                n.draining = 0;
            end else if (s.drain_left == 0) begin
                n.draining = 0;
                n.halted   = 1;
            end else begin
                n.drain_left = s.drain_left - 1;
            end
        end else if (halt_req) begin
            o = '{pc: 0, ifw: 0, bub: 1, fl: 0, hlt: 0};
            n.draining   = 1;
            n.drain_left = dr - 1;
            n.stall_left = 0;
        end else if ((s.stall_left > 0) || haz) begin
            o = '{pc: 0, ifw: 0, bub: 1, fl: 0, hlt: 0};
            n.scnt       = sat_inc(s.scnt, cmax);
            n.stall_left = (s.stall_left > 0) ? s.stall_left - 1 : sc - 1;
        end
    endfunction

    task automatic cmp_outs(input string t, input mout_t o, input mst_t s,
                            input logic pc, input logic ifw, input logic bub,
                            input logic f1, input logic f2, input logic f3,
                            input logic hl, input int sc, input int fc);
        chk({t, ".pc_write"}, pc, o.pc);
        chk({t, ".if_id_write"}, ifw, o.ifw);
        chk({t, ".id_ex_bubble"}, bub, o.bub);
        chk({t, ".if_id_flush"}, f1, o.fl);
        chk({t, ".id_ex_flush"}, f2, o.fl);
        chk({t, ".ex_mem_flush"}, f3, o.fl);
        chk({t, ".halted"}, hl, o.hlt);
        chk({t, ".stall_count"}, sc, s.scnt);
        chk({t, ".flush_count"}, fc, s.fcnt);
    endtask

    bit   chk_en = 1'b0;
    mst_t ma = '{stall_left: 0, drain_left: 0, draining: 0, halted: 0, scnt: 0, fcnt: 0};
    mst_t mb = '{stall_left: 0, drain_left: 0, draining: 0, halted: 0, scnt: 0, fcnt: 0};

    // Per-cycle compare of both instances against the model, then advance the model.
    always @(negedge clk) begin
        mst_t  na, nb;
        mout_t oa, ob;
        if (chk_en) begin
            model(ma, 1, 4, 65535, na, oa);
            model(mb, 3, 4, 3, nb, ob);
            cmp_outs("a", oa, ma, a_pc, a_ifw, a_bub, a_iff, a_idf, a_exf, a_hlt, a_sc, a_fc);
            cmp_outs("b", ob, mb, b_pc, b_ifw, b_bub, b_iff, b_idf, b_exf, b_hlt, b_sc, b_fc);
            ma = na;
            mb = nb;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        memread  = 1'b0;
        id_ex_rt = 5'd0;
        if_id_rs = 5'd0;
        if_id_rt = 5'd0;
        uses_rt  = 1'b0;
        pcsrc    = 1'b0;
        halt_req = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        cyc();
        chk_en = 1'b1;
        #1;
        chk("lit_rst_pc_write", a_pc, 0);
        chk("lit_rst_bubble", a_bub, 1);
        chk("lit_rst_ex_mem_flush", a_exf, 1);
        chk("lit_rst_halted", a_hlt, 0);
        cyc(); rst_n = 1'b1;
        cyc(); #1 chk("lit_idle_pc_write", a_pc, 1);

        // Load-use hazard: lw $2 in ID/EX, add reading $2 in IF/ID.
        cyc(); memread = 1'b1; id_ex_rt = 5'd2; if_id_rs = 5'd2;
        #1;
        chk("lit_haz_pc_write", a_pc, 0);
        chk("lit_haz_if_id_write", a_ifw, 0);
        chk("lit_haz_bubble", a_bub, 1);
        chk("lit_haz_stall_count_before", a_sc, 0);
        cyc(); idle();
        #1;
        chk("lit_after_haz_pc_write", a_pc, 1);
        chk("lit_after_haz_stall_count", a_sc, 1);
        chk("lit_b_still_stalled", b_pc, 0);
        repeat (3) cyc();

        // No false stalls: $0 target, and rt match when rt is not read.
        cyc(); memread = 1'b1; id_ex_rt = 5'd0; if_id_rs = 5'd0;
        #1 chk("lit_r0_no_stall", a_pc, 1);
        cyc(); id_ex_rt = 5'd5; if_id_rs = 5'd1; if_id_rt = 5'd5; uses_rt = 1'b0;
        #1 chk("lit_rt_unused_no_stall", a_pc, 1);
        cyc(); uses_rt = 1'b1;
        #1 chk("lit_rt_used_stall", a_pc, 0);
        cyc(); idle();
        repeat (3) cyc();

        // Branch flush in RUN.
        cyc(); pcsrc = 1'b1;
        #1;
        chk("lit_br_ex_mem_flush", a_exf, 1);
        chk("lit_br_id_ex_flush", a_idf, 1);
        chk("lit_br_if_id_flush", a_iff, 1);
        chk("lit_br_pc_write", a_pc, 1);
        cyc(); idle();
        #1;
        chk("lit_br_flush_count", a_fc, 1);
        chk("lit_br_flush_clear", a_exf, 0);

        // Branch beats hazard in the same cycle.
        cyc(); memread = 1'b1; id_ex_rt = 5'd3; if_id_rs = 5'd3; pcsrc = 1'b1;
        #1;
        chk("lit_br_haz_pc_write", a_pc, 1);
        chk("lit_br_haz_bubble", a_bub, 0);
        cyc(); idle();
        #1;
        chk("lit_br_haz_stall_count", a_sc, 2);
        chk("lit_br_haz_flush_count", a_fc, 2);

        // Flush during a 3-cycle stall (instance b) returns to RUN.
        cyc(); memread = 1'b1; id_ex_rt = 5'd3; if_id_rs = 5'd3;
        cyc(); idle(); pcsrc = 1'b1;
        #1;
        chk("lit_b_stall_flush_pc", b_pc, 1);
        chk("lit_b_stall_flush_ex_mem", b_exf, 1);
        cyc(); idle();
        #1;
        chk("lit_b_after_flush_pc", b_pc, 1);
        chk("lit_b_after_flush_bubble", b_bub, 0);

        // Halt: request held, halted on the 5th cycle after the request.
        cyc(); halt_req = 1'b1;
        #1;
        chk("lit_halt_req_pc", a_pc, 0);
        chk("lit_halt_req_bubble", a_bub, 1);
        repeat (4) cyc();
        #1 chk("lit_halt_c4", a_hlt, 0);
        cyc(); #1 chk("lit_halt_c5", a_hlt, 1);
        cyc(); pcsrc = 1'b1;
        #1;
        chk("lit_halt_ignores_branch", a_exf, 0);
        chk("lit_halt_branch_pc", a_pc, 0);
        cyc(); pcsrc = 1'b0; halt_req = 1'b0;
        #1 chk("lit_halt_drop_still_halted", a_hlt, 1);
        cyc();
        #1;
        chk("lit_resume_pc", a_pc, 1);
        chk("lit_resume_halted", a_hlt, 0);

        // Halt request dropped mid-drain.
        cyc(); halt_req = 1'b1;
        cyc();
        cyc(); halt_req = 1'b0;
        #1 chk("lit_drain_drop_pc", a_pc, 0);
        cyc(); #1 chk("lit_drain_drop_resume", a_pc, 1);

        // Reset in the middle of a stall on instance b.
        cyc(); memread = 1'b1; id_ex_rt = 5'd7; if_id_rs = 5'd7;
        cyc(); idle(); rst_n = 1'b0;
        #1;
        chk("lit_rst_mid_pc", b_pc, 0);
        chk("lit_rst_mid_if_id_flush", b_iff, 1);
        chk("lit_rst_mid_bubble", b_bub, 1);
        chk("lit_rst_mid_halted", b_hlt, 0);
        cyc(); rst_n = 1'b1;
        #1;
        chk("lit_rst_mid_b_stall_count", b_sc, 0);
        chk("lit_rst_mid_b_flush_count", b_fc, 0);
        chk("lit_rst_mid_a_stall_count", a_sc, 0);
        chk("lit_rst_mid_b_pc", b_pc, 1);

        // Saturation: five hazards; instance b has 2-bit counters.
        for (int k = 0; k < 5; k++) begin
            cyc(); memread = 1'b1; id_ex_rt = 5'd4; if_id_rs = 5'd4;
            cyc(); idle();
            repeat (3) cyc();
        end
        #1;
        chk("lit_sat_b_stall_count", b_sc, 3);
        chk("lit_sat_a_stall_count", a_sc, 5);

        repeat (2) cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_control.md
Name: hazard_control

Overview:
- Pipeline sequencing controller for the five-stage MIPS pipeline (fetch, decode, execute, memory, writeback).
- Detects load-use hazards between decode and execute and stalls fetch/decode.
- Squashes younger instructions when a taken branch resolves in the memory stage (EX_MEM_PCSrc).
- Sequences a controlled halt/drain of the pipeline and keeps saturating stall and flush event counters.

Parameters:
- STALL_CYCLES, 1, cycles fetch/decode are frozen per detected load-use hazard (1..15).
- DRAIN_CYCLES, 4, cycles fetch is frozen after a halt request before halted asserts (1..15).
- CNT_W, 16, width of the event counters.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst_n  input  1  synchronous reset, active low.
- IF_ID_rs  input  5  rs field (instr[25:21]) of the instruction in IF/ID.
- IF_ID_rt  input  5  rt field (instr[20:16]) of the instruction in IF/ID.
- IF_ID_uses_rt  input  1  1 when the IF/ID instruction reads rt (R-type, beq, sw).
- ID_EX_memread  input  1  memread control of the instruction in ID/EX.
- ID_EX_rt  input  5  destination rt of the instruction in ID/EX.
- EX_MEM_PCSrc  input  1  taken branch resolved in the memory stage.
- halt_req  input  1  level request to drain and hold the pipeline.
- pc_write  output  1  PC load enable.
- if_id_write  output  1  IF/ID register load enable.
- id_ex_bubble  output  1  zero the wb/m/ex controls entering ID/EX.
- if_id_flush, id_ex_flush, ex_mem_flush  output  1 each  clear the valid/control fields of that pipeline register at the next edge.
- halted  output  1  pipeline drained and frozen.
- stall_count  output  CNT_W  saturating count of stall cycles.
- flush_count  output  CNT_W  saturating count of branch flush events.

Behaviour:
- State register with values RUN, STALL, DRAIN and HALT. A 4-bit down-counter cnt. Control outputs are combinational (Mealy) from state and inputs; the state, cnt and both event counters are registered.
- Reset: while rst_n=0, pc_write=0, if_id_write=0, id_ex_bubble=1, all three flush outputs=1 and halted=0. At the edge, state<=RUN, cnt<=0, stall_count<=0 and flush_count<=0.
- Hazard condition haz: ID_EX_memread & (ID_EX_rt!=0) & ((ID_EX_rt==IF_ID_rs) | (IF_ID_uses_rt & ID_EX_rt==IF_ID_rt)).
- Priority order, applied in every state: reset > EX_MEM_PCSrc > halt_req > haz.
- Branch flush (any state except HALT):
  - When EX_MEM_PCSrc=1, assert if_id_flush, id_ex_flush, ex_mem_flush and pc_write=1 in the same cycle.
  - flush_count increments by 1.
  - Any in-progress STALL is abandoned: state<=RUN, cnt<=0.
  - From DRAIN, the flush is performed and the state stays DRAIN with cnt reloaded to DRAIN_CYCLES-1.
- RUN:
  - With no events: pc_write=1, if_id_write=1, and all bubble/flush outputs are 0.
  - If haz=1: pc_write=0, if_id_write=0, id_ex_bubble=1, and stall_count increments. If STALL_CYCLES>1, state<=STALL with cnt<=STALL_CYCLES-2; otherwise the state stays RUN.
  - If halt_req=1: state<=DRAIN with cnt<=DRAIN_CYCLES-1, and this cycle already has pc_write=0 and id_ex_bubble=1.
- STALL:
  - Outputs are the same as the stalled cycle in RUN, and stall_count increments each cycle.
  - When cnt==0, state<=RUN. Otherwise cnt decrements.
  - haz is not re-evaluated until the state is back in RUN.
- DRAIN:
  - pc_write=0, if_id_write=0, id_ex_bubble=1. Older instructions continue to retire.
  - When cnt==0, state<=HALT. Otherwise cnt decrements.
  - If halt_req drops, state<=RUN on the next edge.
- HALT:
  - halted=1, pc_write=0, if_id_write=0, id_ex_bubble=1.
  - EX_MEM_PCSrc is ignored (the pipeline is empty).
  - When halt_req=0, state<=RUN; halted is 0 in the RUN cycle.
- Counters: stall_count and flush_count saturate at all-ones and never wrap.
- Register $0 never causes a hazard. A non-load instruction in ID/EX never stalls.

Test Plan:
- Hazard stall: lw $2 in ID/EX (memread=1, rt=2) with add using rs=2 in IF/ID, STALL_CYCLES=1. Required: exactly 1 cycle with pc_write=0, if_id_write=0, id_ex_bubble=1; stall_count goes 0→1; pc_write=1 in the next cycle.
- No false stall: ID_EX_rt=0 with rs=0, memread=1. Required: no stall. IF_ID_uses_rt=0 with rt match only. Required: no stall.
- Branch flush: EX_MEM_PCSrc=1 for 1 cycle in RUN. Required: all three flush outputs=1 and pc_write=1 that cycle; flush_count=1.
- Branch beats stall: haz=1 and EX_MEM_PCSrc=1 in the same cycle. Required: flush only, stall_count unchanged. With STALL_CYCLES=3, a flush during STALL returns the state to RUN on the next cycle.
- Halt drain: halt_req=1 held, DRAIN_CYCLES=4. Required: halted=1 on the 5th cycle after the request. Dropping halt_req gives pc_write=1 on the following cycle.
- Reset mid-STALL: rst_n=0 for 1 cycle. Required: outputs take their reset values; state is RUN and both counters are 0 afterwards.
- Saturation: CNT_W=2 with 5 stalls. Required: stall_count stays 3.
